message_scroll_ctrl: RTL and testbench
======================================

# message_scroll_ctrl

Scroll and refresh controller for the 16-character hex message held in the 64-bit message register. It selects a 4-character window starting at a scroll position and time-multiplexes the window onto a 4-digit common-anode seven-segment display, one digit at a time, with a one-cycle blanking gap between digits to prevent ghosting. The scroll position advances automatically on a timer, wrapping modulo 16. It sits between the message register and the seven-segment decoder.

## Interface
- REFRESH_MAX, 4: cycles each digit stays lit per frame; must be ≥1.
- TICK_MAX, 50: cycles between scroll advances; must be ≥2.

- clk  input  1  system clock
- reset  input  1  asynchronous, active-high; clock clk
- message  input  64  character k = message[4k+3:4k], k = 0..15
- hold  input  1  high: scroll timer frozen; refresh continues
- step  input  1  single-cycle advance pulse; exists only with MANUAL_STEP_EN
- an  output  4  anode enables, active-low; an[3] is the leftmost digit
- digit  output  4  character code for the currently enabled anode
- pos  output  4  current scroll position

## Operation
- Window at frame position F: an[3] shows char F, an[2] shows F+1, an[1] shows F+2, an[0] shows F+3. Index arithmetic is 4-bit, so it wraps naturally (F=14 shows E,F,0,1).
- Refresh FSM has 8 states in a fixed cycle: BLANK3 → ON3 → BLANK2 → ON2 → BLANK1 → ON1 → BLANK0 → ON0 → BLANK3.
- BLANK_d lasts 1 cycle:
  - an <= 4'b1111.
  - digit <= char(frame_pos + 3 − d).
  - In BLANK3 only, frame_pos <= pos, and digit <= char(pos) directly.
- ON_d lasts REFRESH_MAX cycles. an <= ~(4'b0001 << d). digit is held.
- Frame length is 4·(REFRESH_MAX+1) cycles.
- A scroll advance during a frame does not affect that frame. It takes effect at the next BLANK3.
- Scroll timer:
  - tick_cnt counts 0..TICK_MAX−1 while hold=0.
  - On the terminal count, tick_cnt wraps to 0 and pos <= pos+1 (mod 16, so 15→0).
  - hold=1 freezes tick_cnt and pos.
- message is sampled combinationally when digit is loaded; it is not latched.
- All outputs are registered.
- Reset values:
  - an=4'b1111, digit=0, pos=0, frame_pos=0.
  - tick_cnt=0, refresh counter=0, state=BLANK3.
- Reset mid-operation takes effect immediately and asynchronously, returning everything to the reset values.

## Timing
- Edge 1 after reset release: BLANK3 executes; digit=char(pos) and an remains 1111.
- Edge 2 after reset release: an=0111.
- Each ON interval is exactly REFRESH_MAX cycles. Each blank interval is exactly 1 cycle.
- pos first increments on edge TICK_MAX after release, provided hold=0 throughout.
- Latency from a pos change to display: visible at the next BLANK3 + 1 cycle. The worst case is one full frame.

## Configuration
- MANUAL_STEP_EN:
  - Defined: the step port exists and the scroll timer is removed. pos <= pos+1 on each cycle with step=1 and hold=0. Steps while hold=1 are ignored. Back-to-back step pulses advance once per cycle.
  - Undefined: no step port; timer-driven scrolling as described above.

## Test plan
- Reset, then release with message=64'hFEDCBA9876543210, REFRESH_MAX=4:
  - an=1111 and digit=0 during reset.
  - an sequence is 0111/1011/1101/1110 with digit 0/1/2/3.
  - Each digit is lit 4 cycles, separated by single 1111 cycles; the frame is 20 cycles.
- TICK_MAX=50, hold=0: pos=1 at edge 50; the next frame shows 1,2,3,4.
- Wrap: run to pos=13 and check the displayed window D,E,F,0. Check the transition pos 15→0, after which the window shows 0,1,2,3.
- Mid-frame advance: pos changes while in ON2. The remainder of the current frame keeps the old window; the new window appears from the next BLANK3.
- hold=1 for 200 cycles: pos and tick_cnt are frozen while the refresh sequence continues unchanged. After hold falls, tick_cnt resumes counting from its frozen value.
- Reset asserted during ON1 with pos=7: an=1111, digit=0 and pos=0 immediately. With MANUAL_STEP_EN defined, three step pulses after reset give pos=3.

Source files
------------

// File: rtl/message_scroll_ctrl.sv
// Scroll/refresh controller: shows a 4-char window of a 16-char hex message on a
// multiplexed 4-digit display. Define MANUAL_STEP_EN to scroll on step pulses instead of a timer.
module message_scroll_ctrl #(
  parameter int REFRESH_MAX = 4,
  parameter int TICK_MAX    = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] message,
  input  logic        hold,
`ifdef MANUAL_STEP_EN
  input  logic        step,
`endif
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic [3:0]  pos
);

  // state   | meaning
  // BLANKd  | all anodes off for one cycle, load digit d's character
  // ONd     | anode d lit for REFRESH_MAX cycles
  // Encoding: bit0 = lit, bits[2:1] = 3 - d, so the sequence is a plain increment.
  typedef enum logic [2:0] {
    BLANK3 = 3'd0, ON3 = 3'd1,
    BLANK2 = 3'd2, ON2 = 3'd3,
    BLANK1 = 3'd4, ON1 = 3'd5,
    BLANK0 = 3'd6, ON0 = 3'd7
  } state_t;

  localparam int RW = (REFRESH_MAX > 1) ? $clog2(REFRESH_MAX) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_MAX - 1);

  state_t        state;
  logic [RW-1:0] rcnt;
  logic [3:0]    frame_pos;
  logic [1:0]    d;

  assign d = ~state[2:1];

  function automatic logic [3:0] char_at(input logic [63:0] m, input logic [3:0] idx);
    return m[{idx, 2'b00} +: 4];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BLANK3;
      rcnt      <= '0;
      an        <= 4'b1111;
      digit     <= 4'h0;
      frame_pos <= 4'h0;
    end else if (!state[0]) begin
      an    <= 4'b1111;
      rcnt  <= '0;
      state <= state_t'(state + 3'd1);
      // The window is latched only at the start of a frame so a frame never mixes positions.
      if (d == 2'd3) begin
        frame_pos <= pos;
        digit     <= char_at(message, pos);
      end else begin
        digit <= char_at(message, frame_pos + {2'b00, ~d});
      end
    end else begin
      an <= ~(4'b0001 << d);
      if (rcnt == R_LAST) begin
        rcnt  <= '0;
        state <= state_t'(state + 3'd1);
      end else begin
        rcnt <= rcnt + RW'(1);
      end
    end
  end

`ifdef MANUAL_STEP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pos <= 4'h0;
    else if (step && !hold)
      pos <= pos + 4'd1;
  end
`else
  localparam int TW = $clog2(TICK_MAX);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_MAX - 1);

  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      pos      <= 4'h0;
    end else if (!hold) begin
      if (tick_cnt == T_LAST) begin
        tick_cnt <= '0;
        pos      <= pos + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_message_scroll_ctrl.sv
// Directed bench for message_scroll_ctrl (REFRESH_MAX=4, TICK_MAX=50); honours MANUAL_STEP_EN.
module tb_message_scroll_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] message;
  logic        hold;
`ifdef MANUAL_STEP_EN
  logic        step;
`endif
  logic [3:0]  an, digit, pos;

  int total = 0;
  int bad   = 0;
  int mtick = 0;
  logic [3:0] mpos = 4'h0;

  message_scroll_ctrl #(.REFRESH_MAX(4), .TICK_MAX(50)) dut (
    .clk(clk), .reset(reset), .message(message), .hold(hold),
`ifdef MANUAL_STEP_EN
    .step(step),
`endif
    .an(an), .digit(digit), .pos(pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge, then advance the scroll model and compare pos.
  task automatic do_edge();
    @(posedge clk);
    #1;
`ifdef MANUAL_STEP_EN
    if (step && !hold) mpos = mpos + 4'd1;
`else
    if (!hold) begin
      if (mtick == 49) begin
        mtick = 0;
        mpos  = mpos + 4'd1;
      end else begin
        mtick++;
      end
    end
`endif
    check("pos", pos, mpos);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_edge();
  endtask

  // 20 edges starting with BLANK3; window start f expected.
  task automatic run_frame(input logic [3:0] f);
    logic [3:0] idx;
    logic [3:0] exp_an;
    int dd;
    for (int j = 0; j < 20; j++) begin
      do_edge();
      dd  = 3 - j / 5;
      idx = f + 4'(3 - dd);
      exp_an = (j % 5 == 0) ? 4'b1111 : ~(4'b0001 << dd);
      check("an", an, exp_an);
      check("digit", digit, message[{idx, 2'b00} +: 4]);
    end
  endtask

  initial begin
    reset   = 1'b1;
    hold    = 1'b0;
    message = 64'hFEDCBA9876543210;
`ifdef MANUAL_STEP_EN
    step = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'b1111);
    check("rst_digit", digit, 4'h0);
    check("rst_pos", pos, 4'h0);
    reset = 1'b0;

`ifdef MANUAL_STEP_EN
    run_frame(4'h0);
    step = 1'b1;
    idle(3);
    step = 1'b0;
    check("three_steps", pos, 4'h3);
    idle(17);
    hold = 1'b1;
    step = 1'b1;
    run_frame(4'h3);
    check("held_steps", pos, 4'h3);
    hold = 1'b0;
    step = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("rst2_pos", pos, 4'h0);
    check("rst2_an", an, 4'b1111);
    mpos = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    step  = 1'b1;
    idle(3);
    step = 1'b0;
    check("steps_after_rst", pos, 4'h3);
`else
    run_frame(4'h0);
    run_frame(4'h0);
    run_frame(4'h0);
    check("pos_at_edge50", pos, 4'h1);
    run_frame(4'h1);
    idle(580);
    run_frame(4'hD);
    idle(120);
    check("pos_wrap", pos, 4'h0);
    run_frame(4'h0);
    hold = 1'b1;
    for (int k = 0; k < 10; k++) run_frame(4'h0);
    check("pos_held", pos, 4'h0);
    hold = 1'b0;
    run_frame(4'h0);
    run_frame(4'h0);
    run_frame(4'h1);
    idle(273);
    check("on1_an", an, 4'b1101);
    check("on1_digit", digit, 4'h8);
    check("on1_pos", pos, 4'h7);
    #3 reset = 1'b1;
    #1;
    check("async_an", an, 4'b1111);
    check("async_digit", digit, 4'h0);
    check("async_pos", pos, 4'h0);
    mpos  = 4'h0;
    mtick = 0;
    @(negedge clk);
    reset = 1'b0;
    run_frame(4'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
